// File: rtl/rf8_op_seq.sv
// rf8_op_seq: multi-cycle instruction sequencer in front of an 8x8 register file.
// Accepts one instruction per valid/ready handshake, reads up to two operands via
// the RF's single combinational read port, computes an ALU result and writes it back.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   in_op/rd/rs1/rs2    opcode and register fields, in_imm immediate for LDI
//   rf_ra, rf_dout      RF read port (combinational read data)
//   rf_wa, rf_din, rf_we RF write port
//   busy, done          status: not idle / one-cycle pulse in writeback
//   flag_z, flag_c      registered zero and carry/borrow flags
module rf8_op_seq #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_dout,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_din,
  output logic          rf_we,
  output logic          busy,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_LDI = 3'd5, OP_SHL = 3'd6, OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, RD1, RD2, WB} state_e;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;
  } instr_t;

  state_e          r_state, w_next;
  instr_t          r_ins;
  logic [DW-1:0]   r_opa, r_opb;
  logic            r_z, r_c;
  logic            w_accept;
  logic [DW:0]     w_res;     // bit DW carries carry/borrow/shifted-out bit
  logic            w_flag_upd;

  assign w_accept = in_valid & in_ready;

  // ALU on the latched operands; only meaningful in WB.
  always_comb begin
    w_res = '0;
    case (op_e'(r_ins.op))
      OP_ADD:  w_res = {1'b0, r_opa} + {1'b0, r_opb};
      OP_SUB:  w_res = {1'b0, r_opa} - {1'b0, r_opb};  // MSB set iff opa < opb
      OP_AND:  w_res = {1'b0, r_opa & r_opb};
      OP_OR:   w_res = {1'b0, r_opa | r_opb};
      OP_XOR:  w_res = {1'b0, r_opa ^ r_opb};
      OP_LDI:  w_res = {1'b0, r_ins.imm};
      OP_SHL:  w_res = {r_opa, 1'b0};
      default: w_res = '0;
    endcase
  end

  assign w_flag_upd = (r_ins.op != OP_LDI) && (r_ins.op != OP_NOP);

  // Next-state and outputs
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    rf_ra    = r_ins.rs1;
    rf_wa    = r_ins.rd;
    rf_din   = w_res[DW-1:0];
    rf_we    = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst;
        if (w_accept) begin
          if (in_op == OP_LDI || in_op == OP_NOP) w_next = WB;
          else                                    w_next = RD1;
        end
      end
      RD1: w_next = (r_ins.op == OP_SHL) ? WB : RD2;
      RD2: begin
        rf_ra  = r_ins.rs2;
        w_next = WB;
      end
      WB: begin
        rf_we  = (r_ins.op != OP_NOP);
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy   = (r_state != IDLE);
  assign flag_z = r_z;
  assign flag_c = r_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ins   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_ins <= '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
      if (r_state == RD1) r_opa <= rf_dout;
      if (r_state == RD2) r_opb <= rf_dout;
      if (r_state == WB && w_flag_upd) begin
        r_z <= (w_res[DW-1:0] == '0);
        r_c <= w_res[DW];
      end
    end
  end

endmodule
